// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 codes, FSM state encoding and the wait-counter width.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned WCNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane logic: store byte mask and lane replication,
// load lane select with sign/zero extension, misalignment/illegal-width check.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = rdata_word_i[{addr_lo_i, 3'b000} +: 8];
      ld_half = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];
   end

   always_comb begin
      be_o    = '0;
      wdata_o = wdata_i;
      rdata_o = '0;
      err_o   = 1'b0;
      if (write_i) begin
         case (funct3_i)
            F3_B: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
               wdata_o = {2{wdata_i[15:0]}};
               if (addr_lo_i[0]) err_o = 1'b1;
               else              be_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
               if (addr_lo_i != 2'b00) err_o = 1'b1;
               else                    be_o  = 4'b1111;
            end
            default: err_o = 1'b1;
         endcase
      end else begin
         case (funct3_i)
            F3_B:  rdata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU: rdata_o = {24'h0, ld_byte};
            F3_H:  if (addr_lo_i[0]) err_o = 1'b1;
                   else rdata_o = {{16{ld_half[15]}}, ld_half};
            F3_HU: if (addr_lo_i[0]) err_o = 1'b1;
                   else rdata_o = {16'h0, ld_half};
            F3_W:  if (addr_lo_i != 2'b00) err_o = 1'b1;
                   else rdata_o = rdata_word_i;
            default: err_o = 1'b1;
         endcase
      end
      // Errored accesses must neither write nor return data.
      if (err_o) begin
         be_o    = '0;
         rdata_o = '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, valid/ready on both sides,
// registered response WAIT_STATES+1 cycles after acceptance.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_STATES);

   state_e                  state_q;
   logic [WCNT_W-1:0]       cnt_q;
   logic                    req_ready_q;
   logic                    rsp_valid_q;
   logic [31:0]             rsp_rdata_q;
   logic                    rsp_err_q;

   logic                    write_q;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [2:0]              funct3_q;
   logic [31:0]             wdata_q;

   logic [31:0]             mem_q [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0]   idx;
   logic [31:0]             word_rd;
   logic [3:0]              be;
   logic [31:0]             wdata_rep;
   logic [31:0]             ld_data;
   logic                    acc_err;
   logic                    commit;
   logic                    unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   assign idx     = addr_q[ADDR_WIDTH+1:2];
   assign word_rd = mem_q[idx];

   dmem_lane_align u_align (
      .funct3_i     (funct3_q),
      .addr_lo_i    (addr_q[1:0]),
      .write_i      (write_q),
      .wdata_i      (wdata_q),
      .rdata_word_i (word_rd),
      .be_o         (be),
      .wdata_o      (wdata_rep),
      .rdata_o      (ld_data),
      .err_o        (acc_err)
   );

   // The final WAIT cycle is the access edge: load capture and store commit coincide.
   assign commit = !rst && (state_q == S_WAIT) && (cnt_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  write_q     <= req_write;
                  addr_q      <= req_addr[ADDR_WIDTH+1:0];
                  funct3_q    <= req_funct3;
                  wdata_q     <= req_wdata;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= ld_data;
                  rsp_err_q   <= acc_err;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit && write_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT_STATES=1.
module tb_dmem_responder;

   localparam int unsigned WS = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int nvec = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .ADDR_WIDTH  (10),
      .WAIT_STATES (WS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait for the response, check it, then hand it off.
   task automatic xact(input string tag, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = a;
      req_funct3 = f3;
      req_wdata  = wd;
      tick();
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, ".latency"}, lat, 32'(WS + 1));
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, ".valid_drop"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("rst.rsp_err",   {31'b0, rsp_err}, 32'd0);

      xact("sw40",  1'b1, 32'h40, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
      xact("lw40",  1'b0, 32'h40, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

      xact("sw40b", 1'b1, 32'h40, 3'b010, 32'h11223344, 32'h0, 1'b0);
      xact("sb41",  1'b1, 32'h41, 3'b000, 32'h000000AA, 32'h0, 1'b0);
      xact("lw40b", 1'b0, 32'h40, 3'b010, 32'h0, 32'h1122AA44, 1'b0);
      xact("lb41",  1'b0, 32'h41, 3'b000, 32'h0, 32'hFFFFFFAA, 1'b0);
      xact("lbu41", 1'b0, 32'h41, 3'b100, 32'h0, 32'h000000AA, 1'b0);

      xact("sh42",  1'b1, 32'h42, 3'b001, 32'h00008001, 32'h0, 1'b0);
      xact("lw40c", 1'b0, 32'h40, 3'b010, 32'h0, 32'h8001AA44, 1'b0);
      xact("lh42",  1'b0, 32'h42, 3'b001, 32'h0, 32'hFFFF8001, 1'b0);
      xact("lhu42", 1'b0, 32'h42, 3'b101, 32'h0, 32'h00008001, 1'b0);
      xact("lh40",  1'b0, 32'h40, 3'b001, 32'h0, 32'hFFFFAA44, 1'b0);
      xact("lb40",  1'b0, 32'h40, 3'b000, 32'h0, 32'h00000044, 1'b0);

      xact("lw42",  1'b0, 32'h42, 3'b010, 32'h0, 32'h0, 1'b1);
      xact("sh43",  1'b1, 32'h43, 3'b001, 32'h0000FFFF, 32'h0, 1'b1);
      xact("sw41",  1'b1, 32'h41, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1);
      xact("ld011", 1'b0, 32'h40, 3'b011, 32'h0, 32'h0, 1'b1);
      xact("st100", 1'b1, 32'h40, 3'b100, 32'hFFFFFFFF, 32'h0, 1'b1);
      xact("lw40d", 1'b0, 32'h40, 3'b010, 32'h0, 32'h8001AA44, 1'b0);
      xact("lwwrap", 1'b0, 32'h1040, 3'b010, 32'h0, 32'h8001AA44, 1'b0);

      // Back-pressured response must hold steady.
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 32'h40;
      req_funct3 = 3'b010;
      tick();
      req_valid = 1'b0;
      begin
         int lat;
         lat = 0;
         while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk("stall.latency", lat, 32'(WS + 1));
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall.valid", {31'b0, rsp_valid}, 32'd1);
         chk("stall.rdata", rsp_rdata, 32'h8001AA44);
         chk("stall.req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("stall.req_ready_after", {31'b0, req_ready}, 32'd1);
      chk("stall.valid_after", {31'b0, rsp_valid}, 32'd0);

      // Reset during WAIT aborts a store before its commit edge.
      xact("sw80z", 1'b1, 32'h80, 3'b010, 32'h0, 32'h0, 1'b0);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h80;
      req_funct3 = 3'b010;
      req_wdata  = 32'h12345678;
      tick();
      req_valid = 1'b0;
      chk("abort.in_wait_ready", {31'b0, req_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort.req_ready", {31'b0, req_ready}, 32'd1);
      xact("lw80", 1'b0, 32'h80, 3'b010, 32'h0, 32'h00000000, 1'b0);
      xact("lw40e", 1'b0, 32'h40, 3'b010, 32'h0, 32'h8001AA44, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
